// File: rtl/apb_mem_bridge_pkg.sv
// Shared definitions for the APB-to-memory bridge.
//   state_e         : bridge FSM state encoding
//   DEF_ADDR_WIDTH  : default address width for APB and memory ports
//   DEF_DATA_WIDTH  : default data width (multiple of 8)
//   DEF_TIMEOUT     : default cycle limit for REQ+WAIT before an error completion
package apb_mem_bridge_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

endpackage : apb_mem_bridge_pkg

// File: rtl/apb_mem_bridge.sv
// APB slave to simple req/gnt/rvalid memory bridge.
// One APB access becomes at most one memory request. Misaligned accesses and
// zero-strobe writes complete locally without touching memory. A request that
// stalls longer than TIMEOUT cycles completes with an error; if the memory had
// already granted it, the bridge drains the late response in FLUSH before
// accepting the next APB access.
//
// Ports
//   clk_i, rst_i              : clock, synchronous active-high reset
//   psel_i .. pstrb_i         : APB request (access phase sampled in IDLE)
//   pready_o, prdata_o,
//   pslverr_o                 : APB completion, prdata/pslverr held until next DONE
//   mem_req_o .. mem_strb_o   : memory request, valid while mem_req_o is high
//   mem_gnt_i                 : memory accepted the request
//   mem_rvalid_i, mem_rdata_i,
//   mem_err_i                 : memory response beat
module apb_mem_bridge
  import apb_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic                    pwrite_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic                    pready_o,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pslverr_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_strb_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_err_i
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0]      CNT_LIM    = CNT_W'(TIMEOUT - 1);
  // Low address bits that must be zero for a word-aligned access.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);

  state_e           state;
  logic [CNT_W-1:0] tmo_cnt;
  // Set when a granted request timed out, so DONE hands over to FLUSH.
  logic             flush_pend;

  logic apb_access;
  logic misaligned;
  logic empty_write;

  assign apb_access  = psel_i && penable_i;
  assign misaligned  = |(paddr_i & ALIGN_MASK);
  assign empty_write = pwrite_i && (pstrb_i == '0);

  assign mem_req_o = (state == ST_REQ);
  assign pready_o  = (state == ST_DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      flush_pend  <= 1'b0;
      prdata_o    <= '0;
      pslverr_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_strb_o  <= '0;
    end else begin
      case (state)
        // Accept an APB access phase; error checks decide whether memory is used.
        ST_IDLE: begin
          if (apb_access) begin
            mem_addr_o  <= paddr_i;
            mem_we_o    <= pwrite_i;
            mem_wdata_o <= pwdata_i;
            mem_strb_o  <= pstrb_i;
            tmo_cnt     <= '0;
            flush_pend  <= 1'b0;
            if (misaligned) begin
              state     <= ST_DONE;
              prdata_o  <= '0;
              pslverr_o <= 1'b1;
            end else if (empty_write) begin
              state     <= ST_DONE;
              prdata_o  <= '0;
              pslverr_o <= 1'b0;
            end else begin
              state <= ST_REQ;
            end
          end
        end

        // Request outstanding. A grant wins over the timeout so that an
        // accepted request is always tracked through WAIT (and FLUSH if late).
        ST_REQ: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (mem_gnt_i && mem_rvalid_i) begin
            state     <= ST_DONE;
            prdata_o  <= mem_we_o ? '0 : mem_rdata_i;
            pslverr_o <= mem_err_i;
          end else if (mem_gnt_i) begin
            state <= ST_WAIT;
          end else if (tmo_cnt >= CNT_LIM) begin
            state     <= ST_DONE;
            prdata_o  <= '0;
            pslverr_o <= 1'b1;
          end
        end

        // Granted, waiting for the response. A response arriving on the
        // expiry cycle still counts as a normal completion.
        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (mem_rvalid_i) begin
            state     <= ST_DONE;
            prdata_o  <= mem_we_o ? '0 : mem_rdata_i;
            pslverr_o <= mem_err_i;
          end else if (tmo_cnt >= CNT_LIM) begin
            state      <= ST_DONE;
            prdata_o   <= '0;
            pslverr_o  <= 1'b1;
            flush_pend <= 1'b1;
          end
        end

        // One-cycle APB completion.
        ST_DONE: begin
          state <= flush_pend ? ST_FLUSH : ST_IDLE;
        end

        // Swallow the late response of a timed-out request; APB stalls here.
        ST_FLUSH: begin
          if (mem_rvalid_i) begin
            state      <= ST_IDLE;
            flush_pend <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : apb_mem_bridge

// File: tb/tb_apb_mem_bridge.sv
// Directed bench for apb_mem_bridge (TIMEOUT=8). Each task drives one scenario
// cycle by cycle and checks outputs at the falling edge.
module tb_apb_mem_bridge;
  import apb_mem_bridge_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic [31:0] paddr_i = '0;
  logic        pwrite_i = 1'b0;
  logic [31:0] pwdata_i = '0;
  logic [3:0]  pstrb_i = '0;
  logic        pready_o;
  logic [31:0] prdata_o;
  logic        pslverr_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_strb_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;

  int checks = 0;
  int failures = 0;

  apb_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .psel_i(psel_i), .penable_i(penable_i), .paddr_i(paddr_i),
    .pwrite_i(pwrite_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  // Setup phase then access phase; returns in the first access-phase cycle.
  task automatic apb_start(input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    step();
    psel_i = 1'b1; penable_i = 1'b0;
    paddr_i = addr; pwrite_i = wr; pwdata_i = wdata; pstrb_i = strb;
    step();
    penable_i = 1'b1;
  endtask

  task automatic apb_release();
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(); step();
    sample();
    checks++; if (pready_o !== 1'b0) begin failures++; $display("FAIL rst_pready got=%0h exp=0", pready_o); end
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req_o); end
    checks++; if (pslverr_o !== 1'b0) begin failures++; $display("FAIL rst_pslverr got=%0h exp=0", pslverr_o); end
    checks++; if (prdata_o !== 32'h0) begin failures++; $display("FAIL rst_prdata got=%h exp=0", prdata_o); end
    checks++; if (mem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr_o); end
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=IDLE", dut.state); end
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_write_fast();
    apb_start(32'h0000_0010, 1'b1, 32'hDEADBEEF, 4'hF);
    sample();
    checks++; if (pready_o !== 1'b0) begin failures++; $display("FAIL wr_pready_c0 got=%0h exp=0", pready_o); end
    step();  // IDLE -> REQ
    sample();
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL wr_mem_req got=%0h exp=1", mem_req_o); end
    checks++; if (mem_we_o !== 1'b1) begin failures++; $display("FAIL wr_mem_we got=%0h exp=1", mem_we_o); end
    checks++; if (mem_addr_o !== 32'h10) begin failures++; $display("FAIL wr_mem_addr got=%h exp=00000010", mem_addr_o); end
    checks++; if (mem_wdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_mem_wdata got=%h exp=deadbeef", mem_wdata_o); end
    checks++; if (mem_strb_o !== 4'hF) begin failures++; $display("FAIL wr_mem_strb got=%h exp=f", mem_strb_o); end
    checks++; if (pready_o !== 1'b0) begin failures++; $display("FAIL wr_pready_c1 got=%0h exp=0", pready_o); end
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555AAAA;
    step();  // REQ -> DONE
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    sample();
    checks++; if (pready_o !== 1'b1) begin failures++; $display("FAIL wr_pready_c2 got=%0h exp=1", pready_o); end
    checks++; if (pslverr_o !== 1'b0) begin failures++; $display("FAIL wr_pslverr got=%0h exp=0", pslverr_o); end
    checks++; if (prdata_o !== 32'h0) begin failures++; $display("FAIL wr_prdata got=%h exp=0", prdata_o); end
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL wr_mem_req_done got=%0h exp=0", mem_req_o); end
    step();  // DONE -> IDLE
    apb_release();
    sample();
    checks++; if (pready_o !== 1'b0) begin failures++; $display("FAIL wr_pready_pulse got=%0h exp=0", pready_o); end
  endtask

  task automatic test_read_slow();
    apb_start(32'h0000_0020, 1'b0, 32'h0, 4'hF);
    step();  // -> REQ
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;  // stray beat, no grant
    sample();
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL rd_mem_req got=%0h exp=1", mem_req_o); end
    checks++; if (mem_we_o !== 1'b0) begin failures++; $display("FAIL rd_mem_we got=%0h exp=0", mem_we_o); end
    checks++; if (mem_addr_o !== 32'h20) begin failures++; $display("FAIL rd_mem_addr got=%h exp=00000020", mem_addr_o); end
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    sample();
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL rd_stray_ignored got=%0h exp=1", mem_req_o); end
    step();
    mem_gnt_i = 1'b1;  // third REQ cycle
    step();  // -> WAIT
    mem_gnt_i = 1'b0;
    sample();
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL rd_wait_req got=%0h exp=0", mem_req_o); end
    checks++; if (pready_o !== 1'b0) begin failures++; $display("FAIL rd_wait_pready got=%0h exp=0", pready_o); end
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
    step();  // -> DONE
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    sample();
    checks++; if (pready_o !== 1'b1) begin failures++; $display("FAIL rd_pready got=%0h exp=1", pready_o); end
    checks++; if (prdata_o !== 32'h12345678) begin failures++; $display("FAIL rd_prdata got=%h exp=12345678", prdata_o); end
    checks++; if (pslverr_o !== 1'b0) begin failures++; $display("FAIL rd_pslverr got=%0h exp=0", pslverr_o); end
    step();
    apb_release();
    sample();
    checks++; if (prdata_o !== 32'h12345678) begin failures++; $display("FAIL rd_prdata_hold got=%h exp=12345678", prdata_o); end
  endtask

  task automatic test_misaligned();
    apb_start(32'h0000_0022, 1'b0, 32'h0, 4'hF);
    sample();
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL mis_req_c0 got=%0h exp=0", mem_req_o); end
    step();  // -> DONE directly
    sample();
    checks++; if (pready_o !== 1'b1) begin failures++; $display("FAIL mis_pready got=%0h exp=1", pready_o); end
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL mis_mem_req got=%0h exp=0", mem_req_o); end
    checks++; if (pslverr_o !== 1'b1) begin failures++; $display("FAIL mis_pslverr got=%0h exp=1", pslverr_o); end
    checks++; if (prdata_o !== 32'h0) begin failures++; $display("FAIL mis_prdata got=%h exp=0", prdata_o); end
    step();
    apb_release();
    sample();
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL mis_req_after got=%0h exp=0", mem_req_o); end
  endtask

  task automatic test_zero_strobe();
    apb_start(32'h0000_0030, 1'b1, 32'h0BADCAFE, 4'h0);
    step();
    sample();
    checks++; if (pready_o !== 1'b1) begin failures++; $display("FAIL zs_pready got=%0h exp=1", pready_o); end
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL zs_mem_req got=%0h exp=0", mem_req_o); end
    checks++; if (pslverr_o !== 1'b0) begin failures++; $display("FAIL zs_pslverr got=%0h exp=0", pslverr_o); end
    step();
    apb_release();
  endtask

  task automatic test_timeout_flush();
    apb_start(32'h0000_0040, 1'b0, 32'h0, 4'hF);
    step();  // edge T: -> REQ
    mem_gnt_i = 1'b1;
    step();  // T+1: -> WAIT
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 6; i++) begin  // T+2 .. T+7
      step();
      sample();
      checks++; if (pready_o !== 1'b0) begin failures++; $display("FAIL to_early_pready cyc=%0d got=%0h exp=0", i, pready_o); end
    end
    step();  // T+8: expiry -> DONE
    sample();
    checks++; if (pready_o !== 1'b1) begin failures++; $display("FAIL to_pready got=%0h exp=1", pready_o); end
    checks++; if (pslverr_o !== 1'b1) begin failures++; $display("FAIL to_pslverr got=%0h exp=1", pslverr_o); end
    checks++; if (prdata_o !== 32'h0) begin failures++; $display("FAIL to_prdata got=%h exp=0", prdata_o); end
    step();  // DONE -> FLUSH
    apb_release();
    apb_start(32'h0000_0044, 1'b0, 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      step();
      sample();
      checks++; if (pready_o !== 1'b0 || mem_req_o !== 1'b0) begin failures++; $display("FAIL to_stall cyc=%0d pready=%0h req=%0h exp=0,0", i, pready_o, mem_req_o); end
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;  // late beat of the timed-out read
    step();  // FLUSH -> IDLE
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    sample();
    checks++; if (pready_o !== 1'b0 || mem_req_o !== 1'b0) begin failures++; $display("FAIL to_flushed pready=%0h req=%0h exp=0,0", pready_o, mem_req_o); end
    step();  // IDLE accepts the stalled read -> REQ
    sample();
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL to_rd2_req got=%0h exp=1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h44) begin failures++; $display("FAIL to_rd2_addr got=%h exp=00000044", mem_addr_o); end
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    sample();
    checks++; if (pready_o !== 1'b1) begin failures++; $display("FAIL to_rd2_pready got=%0h exp=1", pready_o); end
    checks++; if (prdata_o !== 32'hCAFEF00D) begin failures++; $display("FAIL to_rd2_prdata got=%h exp=cafef00d", prdata_o); end
    checks++; if (pslverr_o !== 1'b0) begin failures++; $display("FAIL to_rd2_pslverr got=%0h exp=0", pslverr_o); end
    step();
    apb_release();
  endtask

  task automatic test_timeout_race();
    apb_start(32'h0000_0080, 1'b0, 32'h0, 4'hF);
    step();
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A5A5A;  // arrives on the expiry edge
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    sample();
    checks++; if (pready_o !== 1'b1) begin failures++; $display("FAIL race_pready got=%0h exp=1", pready_o); end
    checks++; if (pslverr_o !== 1'b0) begin failures++; $display("FAIL race_pslverr got=%0h exp=0", pslverr_o); end
    checks++; if (prdata_o !== 32'h5A5A5A5A) begin failures++; $display("FAIL race_prdata got=%h exp=5a5a5a5a", prdata_o); end
    step();
    apb_release();
    sample();
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL race_no_flush got=%0d exp=IDLE", dut.state); end
  endtask

  task automatic test_mem_err();
    apb_start(32'h0000_0050, 1'b0, 32'h0, 4'hF);
    step();
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'h11112222;
    step();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    sample();
    checks++; if (pready_o !== 1'b1) begin failures++; $display("FAIL err_pready got=%0h exp=1", pready_o); end
    checks++; if (pslverr_o !== 1'b1) begin failures++; $display("FAIL err_pslverr got=%0h exp=1", pslverr_o); end
    checks++; if (prdata_o !== 32'h11112222) begin failures++; $display("FAIL err_prdata got=%h exp=11112222", prdata_o); end
    step();
    apb_release();
  endtask

  task automatic test_reset_mid();
    apb_start(32'h0000_0060, 1'b1, 32'hA5A5A5A5, 4'h3);
    step();  // -> REQ
    mem_gnt_i = 1'b1;
    step();  // -> WAIT
    mem_gnt_i = 1'b0;
    sample();
    checks++; if (mem_we_o !== 1'b1) begin failures++; $display("FAIL rm_pre_we got=%0h exp=1", mem_we_o); end
    step();
    rst_i = 1'b1;
    apb_release();
    step();
    rst_i = 1'b0;
    sample();
    checks++; if (pready_o !== 1'b0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || pslverr_o !== 1'b0) begin
      failures++; $display("FAIL rm_ctrl pready=%0h req=%0h we=%0h slverr=%0h exp=0,0,0,0", pready_o, mem_req_o, mem_we_o, pslverr_o); end
    checks++; if (prdata_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_strb_o !== 4'h0) begin
      failures++; $display("FAIL rm_data prdata=%h addr=%h wdata=%h strb=%h exp=0", prdata_o, mem_addr_o, mem_wdata_o, mem_strb_o); end
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("FAIL rm_state got=%0d exp=IDLE", dut.state); end
  endtask

  task automatic test_back_to_back();
    // Fresh transfer right after a mid-transfer reset: no FLUSH in the way.
    apb_start(32'h0000_0070, 1'b0, 32'h0, 4'hF);
    step();
    sample();
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL b2b_req1 got=%0h exp=1", mem_req_o); end
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0A0B0C0D;
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    sample();
    checks++; if (pready_o !== 1'b1 || prdata_o !== 32'h0A0B0C0D) begin failures++; $display("FAIL b2b_rd1 pready=%0h prdata=%h exp=1,0a0b0c0d", pready_o, prdata_o); end
    step();
    apb_release();
    apb_start(32'h0000_0074, 1'b1, 32'h01020304, 4'h8);
    step();
    sample();
    checks++; if (mem_strb_o !== 4'h8 || mem_wdata_o !== 32'h01020304) begin failures++; $display("FAIL b2b_wr2 strb=%h wdata=%h exp=8,01020304", mem_strb_o, mem_wdata_o); end
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
    step();
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    sample();
    checks++; if (pready_o !== 1'b1 || prdata_o !== 32'h0) begin failures++; $display("FAIL b2b_wr2_done pready=%0h prdata=%h exp=1,0", pready_o, prdata_o); end
    step();
    apb_release();
  endtask

  initial begin
    test_reset();
    test_write_fast();
    test_read_slow();
    test_misaligned();
    test_zero_strobe();
    test_timeout_flush();
    test_timeout_race();
    test_mem_err();
    test_reset_mid();
    test_back_to_back();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_apb_mem_bridge
